// File: rtl/controle_pkg.sv
// Shared definitions for the multicycle control unit.
//   state_t     : 4-bit state encoding (also exported on state_dbg)
//   OP_*        : instruction opcodes (instruction bits [31:26])
//   SRCB_*      : ALU operand-B mux selects, shared with the operand mux
//   ALUOP_*     : ALU operation class selects
//   PCSRC_*     : PC source mux selects
package controle_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_WB_LOAD   = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_WB_R      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_BRANCH_NE = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_4    = 2'b01;
    localparam logic [1:0] SRCB_SEXT = 2'b10;
    localparam logic [1:0] SRCB_SHL2 = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/unidade_controle.sv
// Multicycle Moore control FSM for the RISC datapath (R-type, lw, sw, beq,
// j, addi). Datapath controls are decoded from the current state; pc_load
// additionally folds in the ALU zero flag with no extra latency.
//
// Optional feature: define UNIDADE_CONTROLE_BNE_EN to add bne (opcode
// 000101) via state BRANCH_NE (12). Without it, 000101 is an illegal opcode.
//
// Ports:
//   clk, reset       : rising-edge clock, synchronous active-high reset
//   opcode, zero     : instruction bits [31:26], ALU zero flag
//   PCWrite, PCWriteCond, pc_load, IorD, MemRead, MemWrite, IRWrite,
//   MemtoReg, RegDst, RegWrite, ALUSrcA, ALUsrcB, ALUOp, PCSource
//                    : datapath enables and mux selects
//   illegal_op       : one-cycle registered pulse after an undefined opcode
//   state_dbg        : current state encoding
module unidade_controle
    import controle_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       pc_load,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUsrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       illegal_op,
    output logic [3:0] state_dbg
);

    state_t     r_state;
    logic       r_illegal;
    state_t     w_next;
    logic       w_illegal_next;

    logic       w_pc_write;
    logic       w_pc_write_cond;
    logic       w_branch_cond;
    logic       w_iord;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_mem_to_reg;
    logic       w_reg_dst;
    logic       w_reg_write;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_alu_op;
    logic [1:0] w_pc_source;

    // Next-state logic and detection of undefined opcodes in DECODE.
    always_comb begin
        w_next         = S_FETCH;
        w_illegal_next = 1'b0;
        case (r_state)
            S_FETCH: w_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:       w_next = S_EXEC_R;
                    OP_LW, OP_SW:   w_next = S_MEM_ADDR;
                    OP_BEQ:         w_next = S_BRANCH;
                    OP_J:           w_next = S_JUMP;
                    OP_ADDI:        w_next = S_ADDI_EXEC;
`ifdef UNIDADE_CONTROLE_BNE_EN
                    OP_BNE:         w_next = S_BRANCH_NE;
`else
                    OP_BNE: begin
                        w_next         = S_FETCH;
                        w_illegal_next = 1'b1;
                    end
`endif
                    default: begin
                        w_next         = S_FETCH;
                        w_illegal_next = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                // opcode is held stable by the datapath; anything other than
                // lw/sw here can only be corruption, so abandon the instruction
                if (opcode == OP_LW) begin
                    w_next = S_MEM_READ;
                end else if (opcode == OP_SW) begin
                    w_next = S_MEM_WRITE;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_MEM_READ:  w_next = S_WB_LOAD;
            S_WB_LOAD:   w_next = S_FETCH;
            S_MEM_WRITE: w_next = S_FETCH;
            S_EXEC_R:    w_next = S_WB_R;
            S_WB_R:      w_next = S_FETCH;
            S_BRANCH:    w_next = S_FETCH;
            S_JUMP:      w_next = S_FETCH;
            S_ADDI_EXEC: w_next = S_ADDI_WB;
            S_ADDI_WB:   w_next = S_FETCH;
            default:     w_next = S_FETCH;
        endcase
    end

    // State register and registered illegal-opcode pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_illegal <= w_illegal_next;
        end
    end

    // Moore output decode; unlisted outputs stay 0 in every state.
    always_comb begin
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_branch_cond   = 1'b0;
        w_iord          = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        w_mem_to_reg    = 1'b0;
        w_reg_dst       = 1'b0;
        w_reg_write     = 1'b0;
        w_alu_src_a     = 1'b0;
        w_alu_src_b     = SRCB_REG;
        w_alu_op        = ALUOP_ADD;
        w_pc_source     = PCSRC_ALU;
        case (r_state)
            S_FETCH: begin
                w_mem_read  = 1'b1;
                w_ir_write  = 1'b1;
                w_alu_src_b = SRCB_4;
                w_pc_write  = 1'b1;
            end
            S_DECODE: begin
                // precompute branch target while the opcode is decoded
                w_alu_src_b = SRCB_SHL2;
            end
            S_MEM_ADDR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = SRCB_SEXT;
            end
            S_MEM_READ: begin
                w_mem_read = 1'b1;
                w_iord     = 1'b1;
            end
            S_WB_LOAD: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                w_mem_write = 1'b1;
                w_iord      = 1'b1;
            end
            S_EXEC_R: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = ALUOP_FUNCT;
            end
            S_WB_R: begin
                w_reg_write = 1'b1;
                w_reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                w_alu_src_a     = 1'b1;
                w_alu_op        = ALUOP_SUB;
                w_pc_write_cond = 1'b1;
                w_pc_source     = PCSRC_ALUOUT;
                w_branch_cond   = zero;
            end
            S_JUMP: begin
                w_pc_write  = 1'b1;
                w_pc_source = PCSRC_JUMP;
            end
            S_ADDI_EXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = SRCB_SEXT;
            end
            S_ADDI_WB: begin
                w_reg_write = 1'b1;
            end
`ifdef UNIDADE_CONTROLE_BNE_EN
            S_BRANCH_NE: begin
                w_alu_src_a     = 1'b1;
                w_alu_op        = ALUOP_SUB;
                w_pc_write_cond = 1'b1;
                w_pc_source     = PCSRC_ALUOUT;
                w_branch_cond   = ~zero;
            end
`endif
            default: begin
                w_pc_write = 1'b0;
            end
        endcase
    end

    // Enables are suppressed for the whole reset cycle so an aborted
    // instruction cannot commit a memory or register write.
    assign PCWrite     = w_pc_write & ~reset;
    assign PCWriteCond = w_pc_write_cond & ~reset;
    assign pc_load     = (w_pc_write | (w_pc_write_cond & w_branch_cond)) & ~reset;
    assign MemRead     = w_mem_read & ~reset;
    assign MemWrite    = w_mem_write & ~reset;
    assign IRWrite     = w_ir_write & ~reset;
    assign RegWrite    = w_reg_write & ~reset;
    assign IorD        = w_iord;
    assign MemtoReg    = w_mem_to_reg;
    assign RegDst      = w_reg_dst;
    assign ALUSrcA     = w_alu_src_a;
    assign ALUsrcB     = w_alu_src_b;
    assign ALUOp       = w_alu_op;
    assign PCSource    = w_pc_source;
    assign illegal_op  = r_illegal;
    assign state_dbg   = r_state;

endmodule

// File: tb/tb_unidade_controle.sv
// Self-checking bench for unidade_controle: directed reset/abort steps plus
// random instruction streams checked against a per-instruction phase model.
module tb_unidade_controle;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic       zero;
    logic       PCWrite, PCWriteCond, pc_load, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUsrcB, ALUOp, PCSource;
    logic       illegal_op;
    logic [3:0] state_dbg;

    int n_checks = 0;
    int n_errors = 0;
    logic prev_bad = 1'b0;

    unidade_controle dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .pc_load(pc_load),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUsrcB(ALUsrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .illegal_op(illegal_op), .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [16:0] obs_out = {PCWrite, PCWriteCond, pc_load, IorD, MemRead, MemWrite,
                           IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA,
                           ALUsrcB, ALUOp, PCSource};

    // Expected control vector for a state, taken from the state/output table.
    function automatic logic [16:0] exp_out(input int st, input logic z, input logic rst);
        logic pcw, pcwc, ld, iord, mr, mw, irw, m2r, rdst, rw, srca;
        logic [1:0] srcb, aop, psrc;
        {pcw, pcwc, ld, iord, mr, mw, irw, m2r, rdst, rw, srca} = 11'd0;
        srcb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (st)
            0:  begin mr = 1'b1; irw = 1'b1; srcb = 2'b01; pcw = 1'b1; end
            1:  srcb = 2'b11;
            2:  begin srca = 1'b1; srcb = 2'b10; end
            3:  begin mr = 1'b1; iord = 1'b1; end
            4:  begin rw = 1'b1; m2r = 1'b1; end
            5:  begin mw = 1'b1; iord = 1'b1; end
            6:  begin srca = 1'b1; aop = 2'b10; end
            7:  begin rw = 1'b1; rdst = 1'b1; end
            8:  begin srca = 1'b1; aop = 2'b01; pcwc = 1'b1; psrc = 2'b01; ld = z; end
            9:  begin pcw = 1'b1; psrc = 2'b10; end
            10: begin srca = 1'b1; srcb = 2'b10; end
            11: rw = 1'b1;
`ifdef UNIDADE_CONTROLE_BNE_EN
            12: begin srca = 1'b1; aop = 2'b01; pcwc = 1'b1; psrc = 2'b01; ld = ~z; end
`endif
            default: ;
        endcase
        if (pcw) ld = 1'b1;
        if (rst) begin
            pcw = 1'b0; pcwc = 1'b0; ld = 1'b0; mr = 1'b0;
            mw = 1'b0; irw = 1'b0; rw = 1'b0;
        end
        return {pcw, pcwc, ld, iord, mr, mw, irw, m2r, rdst, rw, srca, srcb, aop, psrc};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks state, outputs and illegal_op for the current cycle.
    task automatic check_cycle(input string tag, input int st, input logic ill);
        #1;
        chk($sformatf("%s state", tag), state_dbg, st);
        chk($sformatf("%s outputs st=%0d z=%0b r=%0b", tag, st, zero, reset),
            obs_out, exp_out(st, zero, reset));
        chk($sformatf("%s illegal_op", tag), illegal_op, ill);
    endtask

    // Runs one instruction from FETCH back to the next FETCH.
    task automatic run_instr(input logic [5:0] op);
        int   seq[$];
        logic bad;
        bad = 1'b0;
        case (op)
            6'b100011: seq = {0, 1, 2, 3, 4};
            6'b000000: seq = {0, 1, 6, 7};
            6'b101011: seq = {0, 1, 2, 5};
            6'b001000: seq = {0, 1, 10, 11};
            6'b000100: seq = {0, 1, 8};
            6'b000010: seq = {0, 1, 9};
`ifdef UNIDADE_CONTROLE_BNE_EN
            6'b000101: seq = {0, 1, 12};
`endif
            default: begin seq = {0, 1}; bad = 1'b1; end
        endcase
        opcode = op;
        foreach (seq[i]) begin
            zero = 1'($urandom_range(1, 0));
            check_cycle($sformatf("op=%06b ph%0d", op, i), seq[i], (i == 0) ? prev_bad : 1'b0);
            tick();
        end
        prev_bad = bad;
    endtask

    logic [5:0] op_pool [0:7];

    initial begin
        reset  = 1'b1;
        opcode = 6'b111111;
        zero   = 1'b0;
        op_pool[0] = 6'b000000; op_pool[1] = 6'b100011;
        op_pool[2] = 6'b101011; op_pool[3] = 6'b000100;
        op_pool[4] = 6'b000010; op_pool[5] = 6'b001000;
        op_pool[6] = 6'b000101; op_pool[7] = 6'b111111;

        // Reset held for two cycles: FETCH decode with enables suppressed.
        tick();
        check_cycle("reset1", 0, 1'b0);
        tick();
        check_cycle("reset2", 0, 1'b0);
        reset = 1'b0;
        check_cycle("fetch_after_reset", 0, 1'b0);

        // Directed instruction classes.
        run_instr(6'b100011);
        opcode = 6'b000100; zero = 1'b1;
        tick(); tick();
        check_cycle("beq_taken", 8, 1'b0);
        tick();
        opcode = 6'b000100; zero = 1'b0;
        tick(); tick();
        check_cycle("beq_not_taken", 8, 1'b0);
        tick();
        run_instr(6'b111111);
        run_instr(6'b000101);
        run_instr(6'b000000);

        // Abort in MEM_WRITE: store must not commit, state returns to FETCH.
        opcode = 6'b101011;
        tick(); tick(); tick();
        check_cycle("sw_mem_write", 5, 1'b0);
        reset = 1'b1;
        check_cycle("sw_abort_during_reset", 5, 1'b0);
        tick();
        reset = 1'b0;
        check_cycle("after_abort", 0, 1'b0);

        // Reset in DECODE of an illegal opcode cancels the pulse.
        opcode = 6'b110011;
        tick();
        check_cycle("bad_decode", 1, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_cycle("bad_decode_reset", 0, 1'b0);
        prev_bad = 1'b0;

        // Random instruction stream.
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(3, 0) == 0) run_instr(6'($urandom));
            else run_instr(op_pool[$urandom_range(7, 0)]);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/unidade_controle.md
Name: unidade_controle

Overview:
- Multicycle control FSM for the RISC datapath; sits directly upstream of the ALU operand-B mux and drives its 2-bit ALUsrcB select, plus every other datapath enable/select.
- Moore machine: one state per instruction phase, outputs decoded from current state.
- Supports R-type, lw, sw, beq, j, addi.

Parameters:
- None (opcodes and encodings are fixed package constants).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- opcode  in  6  instruction register bits [31:26]
- zero  in  1  ALU zero flag
- PCWrite  out  1  unconditional PC write
- PCWriteCond  out  1  conditional branch write request
- pc_load  out  1  PC register enable = PCWrite | (PCWriteCond & branch condition)
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read
- MemWrite  out  1  memory write
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  register write data: 0 = ALUOut, 1 = MDR
- RegDst  out  1  destination register: 0 = rt, 1 = rd
- RegWrite  out  1  register file write
- ALUSrcA  out  1  0 = PC, 1 = register A
- ALUsrcB  out  2  00 = reg B, 01 = constant 4, 10 = sign-extend, 11 = sign-extend<<2
- ALUOp  out  2  00 = add, 01 = sub, 10 = funct-decoded
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- illegal_op  out  1  one-cycle pulse on an undefined opcode
- state_dbg  out  4  current state encoding

Behaviour:
- State register updates on the rising clk edge. reset high at an edge -> state = FETCH and illegal_op = 0, regardless of current state (mid-instruction abort allowed).
- While reset is high, all write/read enables are forced to 0: PCWrite, PCWriteCond, pc_load, MemRead, MemWrite, IRWrite, RegWrite. The remaining outputs decode normally from state.
- Unlisted outputs are 0 in each state.
- Encodings and outputs:
  - FETCH (0): MemRead=1, IorD=0, IRWrite=1, ALUSrcA=0, ALUsrcB=01, ALUOp=00, PCSource=00, PCWrite=1 -> DECODE
  - DECODE (1): ALUSrcA=0, ALUsrcB=11, ALUOp=00. Dispatch on opcode:
    - 000000 -> EXEC_R
    - 100011 or 101011 -> MEM_ADDR
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - 001000 -> ADDI_EXEC
    - any other opcode -> FETCH, with illegal_op=1 for exactly the next cycle (registered)
  - MEM_ADDR (2): ALUSrcA=1, ALUsrcB=10, ALUOp=00 -> MEM_READ if lw, MEM_WRITE if sw
  - MEM_READ (3): MemRead=1, IorD=1 -> WB_LOAD
  - WB_LOAD (4): RegWrite=1, MemtoReg=1, RegDst=0 -> FETCH
  - MEM_WRITE (5): MemWrite=1, IorD=1 -> FETCH
  - EXEC_R (6): ALUSrcA=1, ALUsrcB=00, ALUOp=10 -> WB_R
  - WB_R (7): RegWrite=1, RegDst=1, MemtoReg=0 -> FETCH
  - BRANCH (8): ALUSrcA=1, ALUsrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01; pc_load=zero -> FETCH
  - JUMP (9): PCWrite=1, PCSource=10 -> FETCH
  - ADDI_EXEC (10): ALUSrcA=1, ALUsrcB=10, ALUOp=00 -> ADDI_WB
  - ADDI_WB (11): RegWrite=1, RegDst=0, MemtoReg=0 -> FETCH
- Encodings 12-15 are unreachable; if entered, all outputs are 0 and next state = FETCH.
- Cycle counts:
  - lw: 5
  - R-type, sw, addi: 4
  - beq, j: 3
  - illegal opcode: 2
- opcode is sampled only in DECODE and MEM_ADDR; it must stay stable from the IRWrite edge onward, which is the datapath's responsibility.
- pc_load is combinational from state and zero; no extra latency.

Optional Feature:
- Macro: UNIDADE_CONTROLE_BNE_EN.
- Defined:
  - Opcode 000101 dispatches from DECODE to BRANCH_NE (12).
  - BRANCH_NE outputs are identical to BRANCH, except pc_load = PCWriteCond & ~zero.
  - BRANCH_NE -> FETCH.
- Undefined: 000101 is treated as illegal (illegal_op pulse, return to FETCH), and 12 is an unreachable encoding.

Decomposition:
- Package controle_pkg holds:
  - the 4-bit state enum typedef
  - opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_BNE)
  - ALUsrcB select constants (SRCB_REG, SRCB_4, SRCB_SEXT, SRCB_SHL2)
  - ALUOp and PCSource constants
- The ALUsrcB constants are shared with the existing operand mux.
- Single module; next-state and output decode are two always blocks. No sub-module is needed.

Test Plan:
- reset=1 for 2 cycles, then release -> state_dbg=0; FETCH outputs PCWrite=1, IRWrite=1, ALUsrcB=01; no write enables while reset is high.
- opcode=100011 -> state sequence 0,1,2,3,4,0; WB_LOAD has RegWrite=1 and MemtoReg=1; MEM_ADDR has ALUsrcB=10.
- opcode=000100 with zero=1, then zero=0 -> BRANCH shows pc_load=1, then pc_load=0; ALUOp=01 and ALUsrcB=00 in both cases.
- opcode=111111 -> DECODE goes to FETCH; illegal_op=1 for exactly 1 cycle; no RegWrite or MemWrite at any time.
- Assert reset while in MEM_WRITE -> next state is FETCH; MemWrite drops to 0 during the reset cycle.
- With UNIDADE_CONTROLE_BNE_EN, opcode=000101 and zero=0 -> states 0,1,12,0 with pc_load=1 in state 12. Without the macro -> illegal_op pulse.
